// File: rtl/mfcc_pkg.sv
// Shared MFCC types and constants: coefficient type, TX packet framing and the
// serializer state encoding.
package mfcc_pkg;

    localparam int MFCC_NUM_COEFFS  = 13;
    localparam int MFCC_COEFF_WIDTH = 16;

    typedef logic [MFCC_COEFF_WIDTH-1:0] mfcc_data_t;

    localparam logic [7:0] MFCC_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_SYNC,
        TX_SEQ,
        TX_DHI,
        TX_DLO,
        TX_CSUM
    } mfcc_tx_state_t;

    // Packet = sync + seq + two bytes per coefficient + checksum.
    function automatic int MFCC_PKT_BYTES(input int n);
        return 2 * n + 3;
    endfunction

endpackage

// File: rtl/mfcc_stream_tx_if.sv
// Byte stream with valid/ready handshake from the feature serializer to the host link.
interface mfcc_stream_tx_if;

    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/mfcc_stream_tx.sv
// Captures finished MFCC vectors into a two-slot buffer and serializes each as
// a framed byte packet (sync, seq, coefficients MSB first, checksum).
module mfcc_stream_tx
    import mfcc_pkg::*;
#(
    parameter int         NUM_COEFFICIENTS = MFCC_NUM_COEFFS,
    parameter logic [7:0] SYNC_BYTE        = MFCC_SYNC_BYTE
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                mfcc_done_i,
    input  mfcc_data_t [0:NUM_COEFFICIENTS-1]   mfcc_data_i,
    mfcc_stream_tx_if.master                    tx_if,
    output logic                                overflow_o,
    input  logic                                overflow_clr_i,
    output logic [15:0]                         frame_count_o,
    output logic                                busy_o
);

    localparam int                IDX_W    = $clog2(NUM_COEFFICIENTS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_COEFFICIENTS - 1);

    typedef mfcc_data_t [0:NUM_COEFFICIENTS-1] vec_t;

    vec_t             slot_data_q [2];
    logic [7:0]       slot_seq_q  [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;

    mfcc_tx_state_t   state_q;
    logic [IDX_W-1:0] idx_q;
    logic [7:0]       csum_q;
    logic [7:0]       tx_data_q;
    logic             tx_valid_q;
    logic             overflow_q;
    logic             busy_q;
    logic [15:0]      frame_count_q;

    logic             hs;
    logic             release_slot;
    logic             slot_free;
    logic             capture;
    logic             drop;
    logic [IDX_W-1:0] next_idx;
    logic [7:0]       cur_lo;
    logic [7:0]       next_hi;

    // NOTE: every always_comb output is assigned on every path, so no latches are inferred.
    always_comb begin
        hs           = tx_valid_q && tx_if.ready;
        release_slot = (state_q == TX_CSUM) && hs;
        // A full buffer still accepts when its read slot is freed on this very edge.
        slot_free    = (count_q != 2'd2) || release_slot;
        capture      = mfcc_done_i && slot_free;
        drop         = mfcc_done_i && !slot_free;
        count_d      = count_q + {1'b0, capture} - {1'b0, release_slot};
        next_idx     = (idx_q == LAST_IDX) ? idx_q : idx_q + IDX_W'(1);
        cur_lo       = slot_data_q[rd_ptr_q][idx_q][7:0];
        next_hi      = slot_data_q[rd_ptr_q][next_idx][15:8];
    end

    // NOTE: payload registers carry no reset; count_q alone says which slots hold data.
    always_ff @(posedge clk) begin
        if (capture) begin
            slot_data_q[wr_ptr_q] <= mfcc_data_i;
            slot_seq_q[wr_ptr_q]  <= frame_count_q[7:0];
        end
    end

    // NOTE: all state below updates with non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
            state_q       <= TX_IDLE;
            idx_q         <= '0;
            csum_q        <= 8'd0;
            tx_data_q     <= 8'd0;
            tx_valid_q    <= 1'b0;
            overflow_q    <= 1'b0;
            busy_q        <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            count_q <= count_d;
            if (capture) begin
                wr_ptr_q      <= ~wr_ptr_q;
                frame_count_q <= frame_count_q + 16'd1;
            end
            if (release_slot) begin
                rd_ptr_q <= ~rd_ptr_q;
            end

            if (drop) begin
                overflow_q <= 1'b1;
            end else if (overflow_clr_i) begin
                overflow_q <= 1'b0;
            end

            // The FSM is only ever active while a slot is held, so next count alone gives busy.
            busy_q <= (count_d != 2'd0);

            case (state_q)
                TX_IDLE: begin
                    if (count_q != 2'd0 || capture) begin
                        state_q    <= TX_SYNC;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= SYNC_BYTE;
                    end
                end
                TX_SYNC: begin
                    if (hs) begin
                        state_q   <= TX_SEQ;
                        tx_data_q <= slot_seq_q[rd_ptr_q];
                        csum_q    <= 8'd0;
                    end
                end
                TX_SEQ: begin
                    if (hs) begin
                        state_q   <= TX_DHI;
                        idx_q     <= '0;
                        tx_data_q <= slot_data_q[rd_ptr_q][0][15:8];
                        csum_q    <= csum_q + tx_data_q;
                    end
                end
                TX_DHI: begin
                    if (hs) begin
                        state_q   <= TX_DLO;
                        tx_data_q <= cur_lo;
                        csum_q    <= csum_q + tx_data_q;
                    end
                end
                TX_DLO: begin
                    if (hs) begin
                        csum_q <= csum_q + tx_data_q;
                        if (idx_q == LAST_IDX) begin
                            state_q   <= TX_CSUM;
                            tx_data_q <= csum_q + tx_data_q;
                        end else begin
                            state_q   <= TX_DHI;
                            idx_q     <= next_idx;
                            tx_data_q <= next_hi;
                        end
                    end
                end
                TX_CSUM: begin
                    if (hs) begin
                        if (count_q == 2'd2) begin
                            state_q   <= TX_SYNC;
                            tx_data_q <= SYNC_BYTE;
                        end else begin
                            state_q    <= TX_IDLE;
                            tx_valid_q <= 1'b0;
                            tx_data_q  <= 8'd0;
                        end
                    end
                end
                default: begin
                    state_q    <= TX_IDLE;
                    tx_valid_q <= 1'b0;
                    tx_data_q  <= 8'd0;
                end
            endcase
        end
    end

    assign tx_if.data    = tx_data_q;
    assign tx_if.valid   = tx_valid_q;
    assign overflow_o    = overflow_q;
    assign frame_count_o = frame_count_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_mfcc_stream_tx.sv
// Self-checking bench for mfcc_stream_tx: packets are rebuilt from the framing
// rules and compared byte-for-byte against what the stream delivers.
`timescale 1ns/1ps
module tb_mfcc_stream_tx;
    import mfcc_pkg::*;

    localparam int N   = 13;
    localparam int PKT = MFCC_PKT_BYTES(N);

    typedef mfcc_data_t [0:N-1] vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mfcc_done = 1'b0;
    logic        overflow_clr = 1'b0;
    vec_t        mfcc_data = '0;
    logic        overflow;
    logic        busy;
    logic [15:0] frame_count;

    mfcc_stream_tx_if tx_if ();

    mfcc_stream_tx #(
        .NUM_COEFFICIENTS(N),
        .SYNC_BYTE       (8'hA5)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mfcc_done_i   (mfcc_done),
        .mfcc_data_i   (mfcc_data),
        .tx_if         (tx_if),
        .overflow_o    (overflow),
        .overflow_clr_i(overflow_clr),
        .frame_count_o (frame_count),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         model_fc = 0;
    logic [7:0] rx_q[$];
    int         rx_cyc_q[$];
    logic [7:0] exp_q[$];
    logic       stall_pend = 1'b0;
    logic [7:0] stall_byte = 8'd0;

    always @(posedge clk) cyc <= cyc + 1;

    // Collects accepted bytes and checks that a stalled byte is held until taken.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) begin
                checks++;
                if (tx_if.valid !== 1'b1 || tx_if.data !== stall_byte) begin
                    errors++;
                    $display("FAIL stall_hold got valid=%b data=%h want valid=1 data=%h",
                             tx_if.valid, tx_if.data, stall_byte);
                end
            end
            stall_pend = 1'b0;
            if (tx_if.valid === 1'b1 && tx_if.ready === 1'b1) begin
                rx_q.push_back(tx_if.data);
                rx_cyc_q.push_back(cyc);
            end else if (tx_if.valid === 1'b1) begin
                stall_pend = 1'b1;
                stall_byte = tx_if.data;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Reference packet: sync, seq, coefficients MSB first, 8-bit sum of seq and data.
    task automatic model_packet(input logic [7:0] seq, input vec_t v);
        logic [7:0] sum;
        sum = seq;
        exp_q.push_back(8'hA5);
        exp_q.push_back(seq);
        for (int i = 0; i < N; i++) begin
            exp_q.push_back(v[i][15:8]);
            exp_q.push_back(v[i][7:0]);
            sum = sum + v[i][15:8] + v[i][7:0];
        end
        exp_q.push_back(sum);
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < N; i++) v[i] = mfcc_data_t'($urandom);
        return v;
    endfunction

    task automatic pulse(input vec_t v, input logic clr);
        mfcc_data    = v;
        mfcc_done    = 1'b1;
        overflow_clr = clr;
        @(posedge clk); #1;
        mfcc_done    = 1'b0;
        overflow_clr = 1'b0;
    endtask

    task automatic clear_only();
        overflow_clr = 1'b1;
        @(posedge clk); #1;
        overflow_clr = 1'b0;
    endtask

    task automatic wait_bytes(input int n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (rx_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic flush_queues();
        rx_q.delete();
        rx_cyc_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        tx_if.ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (tx_if.valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", tx_if.valid); end
        checks++; if (tx_if.data !== 8'h00) begin errors++; $display("FAIL rst_data got %h want 00", tx_if.data); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b want 0", overflow); end
        checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL rst_frame_count got %0d want 0", frame_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (tx_if.valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL idle_after_rst got valid=%b busy=%b want 0 0", tx_if.valid, busy);
        end
    endtask

    task automatic test_single();
        vec_t v;
        bit   ok;
        for (int i = 0; i < N; i++) v[i] = 16'h0100 + 16'(i);
        model_packet(model_fc[7:0], v);
        tx_if.ready = 1'b1;
        pulse(v, 1'b0);
        model_fc++;
        checks++; if (tx_if.valid !== 1'b1 || tx_if.data !== 8'hA5) begin
            errors++; $display("FAIL latency got valid=%b data=%h want 1 a5", tx_if.valid, tx_if.data);
        end
        checks++; if (frame_count !== 16'(model_fc)) begin
            errors++; $display("FAIL single_frame_count got %0d want %0d", frame_count, model_fc);
        end
        wait_bytes(PKT, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL single_timeout got %0d bytes want %0d", rx_q.size(), PKT);
        end else begin
            for (int i = 0; i < PKT; i++) begin
                checks++;
                if (rx_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL single_byte[%0d] got %h want %h", i, rx_q[i], exp_q[i]);
                end
            end
            checks++; if (rx_q[PKT-1] !== 8'h5B) begin errors++; $display("FAIL single_csum got %h want 5b", rx_q[PKT-1]); end
            checks++; if (rx_cyc_q[PKT-1] - rx_cyc_q[0] !== PKT - 1) begin
                errors++; $display("FAIL single_duration got %0d want %0d", rx_cyc_q[PKT-1] - rx_cyc_q[0] + 1, PKT);
            end
        end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (tx_if.valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_done got valid=%b busy=%b want 0 0", tx_if.valid, busy);
        end
        flush_queues();
    endtask

    task automatic test_backpressure();
        vec_t v;
        int   c;
        for (int p = 0; p < 2; p++) begin
            v = rand_vec();
            model_packet(model_fc[7:0], v);
            tx_if.ready = 1'($urandom_range(0, 1));
            pulse(v, 1'b0);
            model_fc++;
            c = 0;
            while (rx_q.size() < PKT && c < 2000) begin
                tx_if.ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                c++;
            end
            tx_if.ready = 1'b1;
            checks++;
            if (rx_q.size() < PKT) begin
                errors++; $display("FAIL bp_timeout got %0d bytes want %0d", rx_q.size(), PKT);
            end else begin
                for (int i = 0; i < PKT; i++) begin
                    checks++;
                    if (rx_q[i] !== exp_q[i]) begin
                        errors++; $display("FAIL bp_byte[%0d] pkt %0d got %h want %h", i, p, rx_q[i], exp_q[i]);
                    end
                end
            end
            checks++; if (frame_count !== 16'(model_fc)) begin
                errors++; $display("FAIL bp_frame_count got %0d want %0d", frame_count, model_fc);
            end
            repeat (2) @(posedge clk);
            #1;
            flush_queues();
        end
    endtask

    task automatic test_overflow();
        vec_t v0, v1, v2;
        bit   ok;
        v0 = rand_vec(); v1 = rand_vec(); v2 = rand_vec();
        tx_if.ready = 1'b0;
        model_packet(model_fc[7:0], v0);
        model_packet(8'(model_fc + 1), v1);
        pulse(v0, 1'b0);
        @(posedge clk); #1;
        pulse(v1, 1'b0);
        @(posedge clk); #1;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", overflow); end
        pulse(v2, 1'b0);
        model_fc += 2;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
        checks++; if (frame_count !== 16'(model_fc)) begin
            errors++; $display("FAIL ovf_frame_count got %0d want %0d", frame_count, model_fc);
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ovf_busy got %b want 1", busy); end
        tx_if.ready = 1'b1;
        wait_bytes(2 * PKT, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL ovf_timeout got %0d bytes want %0d", rx_q.size(), 2 * PKT);
        end else begin
            for (int i = 0; i < 2 * PKT; i++) begin
                checks++;
                if (rx_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL ovf_byte[%0d] got %h want %h", i, rx_q[i], exp_q[i]);
                end
            end
            checks++; if (rx_cyc_q[PKT] - rx_cyc_q[PKT-1] !== 1) begin
                errors++; $display("FAIL ovf_gap got %0d cycles want 1", rx_cyc_q[PKT] - rx_cyc_q[PKT-1]);
            end
        end
        repeat (2) @(posedge clk);
        #1;
        flush_queues();
    endtask

    task automatic test_overflow_clr();
        vec_t v0, v1, v2;
        bit   ok;
        clear_only();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_alone got %b want 0", overflow); end
        v0 = rand_vec(); v1 = rand_vec(); v2 = rand_vec();
        tx_if.ready = 1'b0;
        model_packet(model_fc[7:0], v0);
        model_packet(8'(model_fc + 1), v1);
        pulse(v0, 1'b0);
        pulse(v1, 1'b0);
        pulse(v2, 1'b1);
        model_fc += 2;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL clr_vs_set got %b want 1", overflow); end
        clear_only();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_later got %b want 0", overflow); end
        tx_if.ready = 1'b1;
        wait_bytes(2 * PKT, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL clr_timeout got %0d bytes want %0d", rx_q.size(), 2 * PKT);
        end else begin
            for (int i = 0; i < 2 * PKT; i++) begin
                checks++;
                if (rx_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL clr_byte[%0d] got %h want %h", i, rx_q[i], exp_q[i]);
                end
            end
        end
        checks++; if (frame_count !== 16'(model_fc)) begin
            errors++; $display("FAIL clr_frame_count got %0d want %0d", frame_count, model_fc);
        end
        repeat (2) @(posedge clk);
        #1;
        flush_queues();
    endtask

    task automatic test_csum_capture();
        vec_t v0, v1, v2;
        bit   ok;
        int   done_cyc;
        v0 = rand_vec(); v1 = rand_vec(); v2 = rand_vec();
        tx_if.ready = 1'b0;
        model_packet(model_fc[7:0], v0);
        model_packet(8'(model_fc + 1), v1);
        model_packet(8'(model_fc + 2), v2);
        pulse(v0, 1'b0);
        pulse(v1, 1'b0);
        tx_if.ready = 1'b1;
        repeat (PKT - 1) begin
            @(posedge clk); #1;
        end
        done_cyc = cyc;
        pulse(v2, 1'b0);
        model_fc += 3;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL cap_overflow got %b want 0", overflow); end
        checks++; if (frame_count !== 16'(model_fc)) begin
            errors++; $display("FAIL cap_frame_count got %0d want %0d", frame_count, model_fc);
        end
        wait_bytes(3 * PKT, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL cap_timeout got %0d bytes want %0d", rx_q.size(), 3 * PKT);
        end else begin
            checks++; if (rx_cyc_q[PKT-1] !== done_cyc) begin
                errors++; $display("FAIL cap_alignment csum at cycle %0d want %0d", rx_cyc_q[PKT-1], done_cyc);
            end
            for (int i = 0; i < 3 * PKT; i++) begin
                checks++;
                if (rx_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL cap_byte[%0d] got %h want %h", i, rx_q[i], exp_q[i]);
                end
            end
        end
        repeat (2) @(posedge clk);
        #1;
        flush_queues();
    endtask

    task automatic test_reset_mid();
        vec_t v;
        bit   ok;
        tx_if.ready = 1'b1;
        pulse(rand_vec(), 1'b0);
        wait_bytes(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_timeout got %0d bytes want 10", rx_q.size()); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (tx_if.valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", tx_if.valid); end
        checks++; if (tx_if.data !== 8'h00) begin errors++; $display("FAIL mid_data got %h want 00", tx_if.data); end
        checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL mid_frame_count got %0d want 0", frame_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow got %b want 0", overflow); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        flush_queues();
        model_fc = 0;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (rx_q.size() !== 0 || tx_if.valid !== 1'b0) begin
            errors++; $display("FAIL mid_resume got %0d bytes valid=%b want 0 0", rx_q.size(), tx_if.valid);
        end
        v = rand_vec();
        model_packet(8'h00, v);
        pulse(v, 1'b0);
        model_fc++;
        wait_bytes(PKT, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL fresh_timeout got %0d bytes want %0d", rx_q.size(), PKT);
        end else begin
            checks++; if (rx_q[1] !== 8'h00) begin errors++; $display("FAIL fresh_seq got %h want 00", rx_q[1]); end
            for (int i = 0; i < PKT; i++) begin
                checks++;
                if (rx_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL fresh_byte[%0d] got %h want %h", i, rx_q[i], exp_q[i]);
                end
            end
        end
        checks++; if (frame_count !== 16'(model_fc)) begin
            errors++; $display("FAIL fresh_frame_count got %0d want %0d", frame_count, model_fc);
        end
        flush_queues();
    endtask

    initial begin
        tx_if.ready = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_overflow_clr();
        test_csum_capture();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
